// File: rtl/program_loader_pkg.sv
// Shared definitions for the MiniAlu instruction-store loader.
package program_loader_pkg;

    // Loader control states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_BYTE  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } loader_state_t;

    localparam logic [7:0] LDR_HEADER     = 8'hA5;
    localparam int         LDR_INSTR_W    = 28;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_word_packer.sv
// Packs four bytes (MSB first) into one 28-bit instruction word.
// Only the low nibble of the first byte survives; it becomes the opcode.
module loader_word_packer
    import program_loader_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_load,
    input  logic [7:0]             i_byte,
    output logic [LDR_INSTR_W-1:0] o_word_next,
    output logic                   o_first,
    output logic                   o_last
);

    localparam int SHIFT_W = LDR_INSTR_W - 8;

    logic [SHIFT_W-1:0] r_shift;
    logic [1:0]         r_idx;

    // Shift accepted bytes in and track the byte position within the word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_shift <= {r_shift[SHIFT_W-9:0], i_byte};
            r_idx   <= r_idx + 2'd1;
        end
    end

    // The word as it will be once the current byte is shifted in
    assign o_word_next = {r_shift, i_byte};
    assign o_first     = (r_idx == 2'd0);
    assign o_last      = (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Writer side of the MiniAlu instruction store: receives framed byte stream,
// writes packed instructions from address 0 and holds the CPU in reset until
// a complete frame with a matching checksum has been loaded.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] HEADER  = LDR_HEADER,
    parameter int         INSTR_W = LDR_INSTR_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [7:0]         iByte,
    input  logic               iByteValid,
    output logic               oByteReady,
    output logic               oWriteEnable,
    output logic [ADDR_W-1:0]  oWriteAddress,
    output logic [INSTR_W-1:0] oInstruction,
    output logic               oCpuReset,
    output logic               oDone,
    output logic               oError
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    loader_state_t       r_state;
    logic                r_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_cpu_rst;
    logic                r_done;
    logic                r_err;
    logic [7:0]          r_chk;
    logic [7:0]          r_count;
    logic [7:0]          r_words;

    logic                   w_acc;
    logic                   w_clear;
    logic                   w_load;
    logic [LDR_INSTR_W-1:0] w_word_next;
    logic                   w_first;
    logic                   w_last;

    assign w_acc   = iByteValid & r_ready;
    assign w_clear = w_acc & (r_state == ST_COUNT);
    assign w_load  = w_acc & (r_state == ST_BYTE);

    loader_word_packer u_packer (
        .i_clk       (Clock),
        .i_rst_n     (Reset),
        .i_clear     (w_clear),
        .i_load      (w_load),
        .i_byte      (iByte),
        .o_word_next (w_word_next),
        .o_first     (w_first),
        .o_last      (w_last)
    );

    // Frame FSM with registered outputs, address/word counters and checksum
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_instr   <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_chk     <= '0;
            r_count   <= '0;
            r_words   <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    // Only a header starts (or restarts) a load; anything else is dropped
                    if (w_acc && (iByte == HEADER)) begin
                        r_state   <= ST_COUNT;
                        r_cpu_rst <= 1'b1;
                        r_done    <= 1'b0;
                        r_err     <= 1'b0;
                        r_chk     <= '0;
                    end
                end
                ST_COUNT: begin
                    if (w_acc) begin
                        r_count <= iByte;
                        r_chk   <= r_chk ^ iByte;
                        r_addr  <= '0;
                        r_words <= '0;
                        if (int'(iByte) > DEPTH) begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end else if (iByte == 8'd0) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_state <= ST_BYTE;
                        end
                    end
                end
                ST_BYTE: begin
                    if (w_acc) begin
                        r_chk <= r_chk ^ iByte;
                        // Opcode is 4 bits: a non-zero upper nibble is a malformed word
                        if (w_first && (iByte[7:4] != 4'd0)) begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end else if (w_last) begin
                            r_state <= ST_WRITE;
                            r_ready <= 1'b0;
                            r_we    <= 1'b1;
                            r_instr <= w_word_next;
                        end
                    end
                end
                ST_WRITE: begin
                    r_ready <= 1'b1;
                    r_addr  <= r_addr + ADDR_ONE;
                    r_words <= r_words + 8'd1;
                    if ((r_words + 8'd1) == r_count) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_state <= ST_BYTE;
                    end
                end
                ST_CHECK: begin
                    if (w_acc) begin
                        if (iByte == r_chk) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oByteReady    = r_ready;
    assign oWriteEnable  = r_we;
    assign oWriteAddress = r_addr;
    assign oInstruction  = r_instr;
    assign oCpuReset     = r_cpu_rst;
    assign oDone         = r_done;
    assign oError        = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame loads, checksum errors, empty frames,
// bad opcodes, back-pressure with continuous valid and asynchronous reset.
module tb_program_loader;

    logic        Clock;
    logic        Reset;
    logic [7:0]  iByte;
    logic        iByteValid;
    logic        oByteReady;
    logic        oWriteEnable;
    logic [7:0]  oWriteAddress;
    logic [27:0] oInstruction;
    logic        oCpuReset;
    logic        oDone;
    logic        oError;

    int errors = 0;
    int checks = 0;
    int rdy_low = 0;
    logic [7:0]  wa[$];
    logic [27:0] wd[$];

    program_loader #(.ADDR_W(8), .HEADER(8'hA5), .INSTR_W(28)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iByte         (iByte),
        .iByteValid    (iByteValid),
        .oByteReady    (oByteReady),
        .oWriteEnable  (oWriteEnable),
        .oWriteAddress (oWriteAddress),
        .oInstruction  (oInstruction),
        .oCpuReset     (oCpuReset),
        .oDone         (oDone),
        .oError        (oError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Record every write strobe and every cycle with ready low
    always @(negedge Clock) begin
        if (Reset && oWriteEnable) begin
            wa.push_back(oWriteAddress);
            wd.push_back(oInstruction);
        end
        if (Reset && !oByteReady) rdy_low = rdy_low + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted. Valid stays high.
    task automatic send(input logic [7:0] b);
        int n = 0;
        iByte = b;
        iByteValid = 1'b1;
        while (!oByteReady && n < 8) begin
            @(negedge Clock);
            n++;
        end
        check("ready_timeout", 32'(n < 8), 32'd1);
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic idle(input int cycles);
        iByteValid = 1'b0;
        repeat (cycles) @(negedge Clock);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},  32'(oByteReady),    32'd1);
        check({tag, "_we"},   32'(oWriteEnable),  32'd0);
        check({tag, "_addr"}, 32'(oWriteAddress), 32'd0);
        check({tag, "_ins"},  32'(oInstruction),  32'd0);
        check({tag, "_cpu"},  32'(oCpuReset),     32'd1);
        check({tag, "_done"}, 32'(oDone),         32'd0);
        check({tag, "_err"},  32'(oError),        32'd0);
    endtask

    initial begin
        Reset = 1'b0;
        iByte = 8'h00;
        iByteValid = 1'b0;
        repeat (3) @(negedge Clock);
        check_reset_vals("rst");
        Reset = 1'b1;
        idle(2);

        // Test 1: two-word frame, checksum 02^01^..^08 = 0A
        send(8'h33);   // stray byte in IDLE is dropped
        send(8'hA5); send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("t1_we_lat",  32'(oWriteEnable),  32'd1);
        check("t1_addr0",   32'(oWriteAddress), 32'd0);
        check("t1_ins0",    32'(oInstruction),  32'h1020304);
        check("t1_rdy_low", 32'(oByteReady),    32'd0);
        send(8'h05); send(8'h06); send(8'h07); send(8'h08);
        send(8'h0A);
        idle(2);
        check("t1_nwr",  32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("t1_wa0", 32'(wa[0]), 32'd0);
            check("t1_wd0", 32'(wd[0]), 32'h1020304);
            check("t1_wa1", 32'(wa[1]), 32'd1);
            check("t1_wd1", 32'(wd[1]), 32'h5060708);
        end
        check("t1_done", 32'(oDone),     32'd1);
        check("t1_cpu",  32'(oCpuReset), 32'd0);
        check("t1_err",  32'(oError),    32'd0);

        // Test 2: same frame, wrong checksum
        wa.delete(); wd.delete();
        send(8'hA5);
        check("t2_cpu_hold", 32'(oCpuReset), 32'd1);
        check("t2_done_clr", 32'(oDone),     32'd0);
        send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05); send(8'h06); send(8'h07); send(8'h08);
        send(8'h0B);
        idle(2);
        check("t2_nwr",  32'(wa.size()), 32'd2);
        check("t2_err",  32'(oError),    32'd1);
        check("t2_cpu",  32'(oCpuReset), 32'd1);
        check("t2_done", 32'(oDone),     32'd0);

        // Test 3: empty frame, then a new header re-holds the CPU
        wa.delete(); wd.delete();
        send(8'hA5); send(8'h00); send(8'h00);
        idle(3);
        check("t3_nwr",  32'(wa.size()), 32'd0);
        check("t3_done", 32'(oDone),     32'd1);
        check("t3_cpu",  32'(oCpuReset), 32'd0);
        check("t3_err",  32'(oError),    32'd0);
        send(8'hA5);
        idle(1);
        check("t3_cpu_re",  32'(oCpuReset), 32'd1);
        check("t3_done_re", 32'(oDone),     32'd0);

        // Test 4: (continuing after the A5) N=1, first byte has a non-zero upper nibble
        send(8'h01); send(8'h10);
        check("t4_err_now", 32'(oError), 32'd1);
        send(8'h02); send(8'h03); send(8'h04); send(8'h00);
        idle(2);
        check("t4_err_hold", 32'(oError),    32'd1);
        check("t4_nwr",      32'(wa.size()), 32'd0);
        check("t4_done",     32'(oDone),     32'd0);
        check("t4_cpu",      32'(oCpuReset), 32'd1);

        // Test 5: valid held high throughout; checksum = D3
        rdy_low = 0;
        send(8'hA5); send(8'h02);
        send(8'h0F); send(8'hEE); send(8'hDD); send(8'hCC);
        send(8'h03); send(8'h33); send(8'h44); send(8'h55);
        send(8'hD3);
        idle(2);
        check("t5_rdy_low", 32'(rdy_low),    32'd2);
        check("t5_nwr",     32'(wa.size()),  32'd2);
        if (wa.size() == 2) begin
            check("t5_wa0", 32'(wa[0]), 32'd0);
            check("t5_wd0", 32'(wd[0]), 32'hFEEDDCC);
            check("t5_wa1", 32'(wa[1]), 32'd1);
            check("t5_wd1", 32'(wd[1]), 32'h3334455);
        end
        check("t5_done", 32'(oDone),     32'd1);
        check("t5_cpu",  32'(oCpuReset), 32'd0);

        // Test 6: asynchronous reset after the 2nd payload byte, then a fresh frame
        wa.delete(); wd.delete();
        send(8'hA5); send(8'h01); send(8'h01); send(8'h23);
        idle(0);
        #2;
        Reset = 1'b0;
        #1;
        check_reset_vals("t6_rst");
        @(negedge Clock);
        Reset = 1'b1;
        idle(2);
        check("t6_nwr_rst", 32'(wa.size()), 32'd0);
        send(8'hA5); send(8'h01);
        send(8'h01); send(8'h23); send(8'h45); send(8'h67);
        send(8'h01);
        idle(2);
        check("t6_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("t6_wa0", 32'(wa[0]), 32'd0);
            check("t6_wd0", 32'(wd[0]), 32'h1234567);
        end
        check("t6_done", 32'(oDone),     32'd1);
        check("t6_cpu",  32'(oCpuReset), 32'd0);
        check("t6_err",  32'(oError),    32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
